// File: rtl/fmamult_arb.sv
// fmamult_arb: pipelined significand multiplier shared by the FMA (req 0) and div/sqrt (req 1) units.
// Define FMAMULT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fmamult_arb #(
    parameter int NF     = 52,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Flush,
    input  logic            Req0Valid,
    input  logic            Req1Valid,
    output logic            Req0Ready,
    output logic            Req1Ready,
    input  logic [NF:0]     X0m,
    input  logic [NF:0]     Y0m,
    input  logic [NF:0]     X1m,
    input  logic [NF:0]     Y1m,
    output logic            ResValid,
    input  logic            ResReady,
    output logic            ResSrc,
    output logic [2*NF+1:0] Pm
);
    localparam int PW = 2*NF+2;
    logic [STAGES-1:0] vld, src;
    logic [PW-1:0] prod [STAGES];
    logic advance, gnt1, take;
    logic [NF:0] xm, ym;
    logic [PW-1:0] mul;
    assign advance = ~Flush & (~vld[STAGES-1] | ResReady);
`ifdef FMAMULT_ARB_RR_EN
    logic last_gnt;
    assign gnt1 = Req1Valid & (~Req0Valid | ~last_gnt);
    always_ff @(posedge clk or posedge reset)
        if (reset) last_gnt <= 1'b1;
        else if (take) last_gnt <= gnt1;
`else
    assign gnt1 = Req1Valid & ~Req0Valid;
`endif
    assign Req0Ready = advance & Req0Valid & ~gnt1;
    assign Req1Ready = advance & gnt1;
    assign take = Req0Ready | Req1Ready;
    assign xm = gnt1 ? X1m : X0m;
    assign ym = gnt1 ? Y1m : Y0m;
    // Full product is formed at issue; later stages only carry it, leaving room to retime.
    assign mul = {{(NF+1){1'b0}}, xm} * {{(NF+1){1'b0}}, ym};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            src <= '0;
            for (int i = 0; i < STAGES; i++) prod[i] <= '0;
        end else if (Flush) begin
            vld <= '0;
        end else if (advance) begin
            for (int i = STAGES-1; i > 0; i--) begin
                vld[i]  <= vld[i-1];
                src[i]  <= src[i-1];
                prod[i] <= prod[i-1];
            end
            vld[0]  <= take;
            src[0]  <= gnt1;
            prod[0] <= mul;
        end
    end
    assign ResValid = vld[STAGES-1];
    assign ResSrc   = src[STAGES-1];
    assign Pm       = prod[STAGES-1];
endmodule

// File: tb/tb_fmamult_arb.sv
// tb_fmamult_arb: directed checks of arbitration, latency, stall, flush and reset for fmamult_arb.
module tb_fmamult_arb;
    localparam int NF = 52;
    logic clk = 1'b0;
    logic reset, Flush, Req0Valid, Req1Valid, Req0Ready, Req1Ready, ResValid, ResReady, ResSrc;
    logic [NF:0] X0m, Y0m, X1m, Y1m;
    logic [2*NF+1:0] Pm;
    int tests = 0;
    int fails = 0;

    fmamult_arb #(.NF(NF), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
        .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
        .X0m(X0m), .Y0m(Y0m), .X1m(X1m), .Y1m(Y1m),
        .ResValid(ResValid), .ResReady(ResReady), .ResSrc(ResSrc), .Pm(Pm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; Flush = 0; Req0Valid = 0; Req1Valid = 0; ResReady = 1;
        X0m = '0; Y0m = '0; X1m = '0; Y1m = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ResValid); end
        tests++; if (ResSrc !== 1'b0) begin fails++; $display("FAIL reset_src got %0b want 0", ResSrc); end
        tests++; if (Pm !== '0) begin fails++; $display("FAIL reset_pm got %0h want 0", Pm); end
        reset = 0;
        step();
    endtask

    task automatic test_arb();
        logic [3:0] g1;
        int k;
`ifdef FMAMULT_ARB_RR_EN
        g1 = 4'b1010;
`else
        g1 = 4'b0000;
`endif
        ResReady = 1; X0m = 2; Y0m = 3; X1m = 7; Y1m = 11;
        for (int i = 0; i < 6; i++) begin
            Req0Valid = (i < 4); Req1Valid = (i < 4);
            #1;
            tests++; if (Req0Ready !== ((i < 4) && !g1[i[1:0]])) begin fails++; $display("FAIL arb_r0[%0d] got %0b want %0b", i, Req0Ready, (i < 4) && !g1[i[1:0]]); end
            tests++; if (Req1Ready !== ((i < 4) && g1[i[1:0]])) begin fails++; $display("FAIL arb_r1[%0d] got %0b want %0b", i, Req1Ready, (i < 4) && g1[i[1:0]]); end
            if (i >= 2) begin
                k = i - 2;
                tests++; if (ResValid !== 1'b1) begin fails++; $display("FAIL arb_valid[%0d] got %0b want 1", k, ResValid); end
                tests++; if (ResSrc !== g1[k[1:0]]) begin fails++; $display("FAIL arb_src[%0d] got %0b want %0b", k, ResSrc, g1[k[1:0]]); end
                tests++; if (Pm !== (g1[k[1:0]] ? 106'd77 : 106'd6)) begin fails++; $display("FAIL arb_pm[%0d] got %0d want %0d", k, Pm, g1[k[1:0]] ? 77 : 6); end
            end
            step();
        end
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL arb_drain got %0b want 0", ResValid); end
        step();
    endtask

    task automatic test_single();
        ResReady = 1; Req0Valid = 1; X0m = 3; Y0m = 5;
        #1;
        tests++; if (Req0Ready !== 1'b1) begin fails++; $display("FAIL single_ready got %0b want 1", Req0Ready); end
        step();
        Req0Valid = 0;
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL single_early got %0b want 0", ResValid); end
        step();
        #1;
        tests++; if (ResValid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", ResValid); end
        tests++; if (ResSrc !== 1'b0) begin fails++; $display("FAIL single_src got %0b want 0", ResSrc); end
        tests++; if (Pm !== 106'd15) begin fails++; $display("FAIL single_pm got %0d want 15", Pm); end
        step();
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL single_once got %0b want 0", ResValid); end
        step();
    endtask

    task automatic test_max();
        logic [2*NF+1:0] e;
        e = {52'hF_FFFF_FFFF_FFFF, 54'd1};
        ResReady = 1; Req1Valid = 1; X1m = 53'h1F_FFFF_FFFF_FFFF; Y1m = 53'h1F_FFFF_FFFF_FFFF;
        #1;
        tests++; if (Req1Ready !== 1'b1) begin fails++; $display("FAIL max_ready got %0b want 1", Req1Ready); end
        step();
        Req1Valid = 0;
        step();
        #1;
        tests++; if (ResValid !== 1'b1) begin fails++; $display("FAIL max_valid got %0b want 1", ResValid); end
        tests++; if (ResSrc !== 1'b1) begin fails++; $display("FAIL max_src got %0b want 1", ResSrc); end
        tests++; if (Pm !== e) begin fails++; $display("FAIL max_pm got %0h want %0h", Pm, e); end
        step();
    endtask

    task automatic test_stall();
        ResReady = 1; Req0Valid = 1; X0m = 4; Y0m = 5;
        step();
        X0m = 6; Y0m = 7;
        step();
        ResReady = 0; X0m = 8; Y0m = 9; Req1Valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (ResValid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %0b want 1", i, ResValid); end
            tests++; if (Pm !== 106'd20) begin fails++; $display("FAIL stall_pm[%0d] got %0d want 20", i, Pm); end
            tests++; if (Req0Ready !== 1'b0) begin fails++; $display("FAIL stall_r0[%0d] got %0b want 0", i, Req0Ready); end
            tests++; if (Req1Ready !== 1'b0) begin fails++; $display("FAIL stall_r1[%0d] got %0b want 0", i, Req1Ready); end
            step();
        end
        Req1Valid = 0; ResReady = 1;
        #1;
        tests++; if (Req0Ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %0b want 1", Req0Ready); end
        tests++; if (Pm !== 106'd20) begin fails++; $display("FAIL stall_out0 got %0d want 20", Pm); end
        step();
        Req0Valid = 0;
        #1;
        tests++; if (ResValid !== 1'b1 || Pm !== 106'd42) begin fails++; $display("FAIL stall_out1 got v=%0b pm=%0d want v=1 pm=42", ResValid, Pm); end
        step();
        #1;
        tests++; if (ResValid !== 1'b1 || Pm !== 106'd72) begin fails++; $display("FAIL stall_out2 got v=%0b pm=%0d want v=1 pm=72", ResValid, Pm); end
        step();
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL stall_drain got %0b want 0", ResValid); end
        step();
    endtask

    task automatic test_flush();
        ResReady = 1; Req0Valid = 1; X0m = 10; Y0m = 10;
        step();
        X0m = 11; Y0m = 11;
        step();
        Flush = 1; X0m = 12; Y0m = 12;
        #1;
        tests++; if (Req0Ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %0b want 0", Req0Ready); end
        step();
        Flush = 0; X0m = 13; Y0m = 13;
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", ResValid); end
        tests++; if (Req0Ready !== 1'b1) begin fails++; $display("FAIL flush_reissue got %0b want 1", Req0Ready); end
        step();
        Req0Valid = 0;
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL flush_stale got %0b want 0", ResValid); end
        step();
        #1;
        tests++; if (ResValid !== 1'b1 || Pm !== 106'd169) begin fails++; $display("FAIL flush_after got v=%0b pm=%0d want v=1 pm=169", ResValid, Pm); end
        step();
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL flush_drain got %0b want 0", ResValid); end
        step();
    endtask

    task automatic test_reset_mid();
        ResReady = 1; Req0Valid = 1; X0m = 3; Y0m = 7;
        step();
        X0m = 5; Y0m = 5;
        step();
        Req0Valid = 0;
        #1;
        tests++; if (ResValid !== 1'b1 || Pm !== 106'd21) begin fails++; $display("FAIL rmid_pre got v=%0b pm=%0d want v=1 pm=21", ResValid, Pm); end
        #2;
        reset = 1;
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %0b want 0", ResValid); end
        tests++; if (Pm !== '0) begin fails++; $display("FAIL rmid_pm got %0d want 0", Pm); end
        step();
        reset = 0;
        #1;
        tests++; if (ResValid !== 1'b0) begin fails++; $display("FAIL rmid_discard got %0b want 0", ResValid); end
        step();
        Req0Valid = 1; Req1Valid = 1; X0m = 6; Y0m = 6; X1m = 9; Y1m = 9;
        #1;
        tests++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin fails++; $display("FAIL rmid_first got r0=%0b r1=%0b want r0=1 r1=0", Req0Ready, Req1Ready); end
        step();
        Req0Valid = 0; Req1Valid = 0;
        step();
        #1;
        tests++; if (ResValid !== 1'b1 || ResSrc !== 1'b0 || Pm !== 106'd36) begin fails++; $display("FAIL rmid_result got v=%0b s=%0b pm=%0d want v=1 s=0 pm=36", ResValid, ResSrc, Pm); end
        step();
    endtask

    initial begin
        test_reset();
        test_arb();
        test_single();
        test_max();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
